// File: rtl/idec.sv
// rtl/idec.sv - instruction decoder stage: registered field split and one-hot opcode
module idec (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [20:0] pm_cont,
  output logic [3:0]  opcode,
  output logic [2:0]  op1,
  output logic [2:0]  op2,
  output logic [2:0]  op3,
  output logic [7:0]  data,
  output logic [15:0] op_dec,
  output logic        valid
);

  logic [3:0]  r_opcode;
  logic [2:0]  r_op1;
  logic [2:0]  r_op2;
  logic [2:0]  r_op3;
  logic [7:0]  r_data;
  logic [15:0] r_op_dec;
  logic        r_valid;

  // op_dec is decoded from the incoming word so it lands on the same edge as opcode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opcode <= 4'h0;
      r_op1    <= 3'h0;
      r_op2    <= 3'h0;
      r_op3    <= 3'h0;
      r_data   <= 8'h00;
      r_op_dec <= 16'h0000;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= en;
      if (en) begin
        r_opcode <= pm_cont[20:17];
        r_op1    <= pm_cont[16:14];
        r_op2    <= pm_cont[13:11];
        r_op3    <= pm_cont[10:8];
        r_data   <= pm_cont[7:0];
        r_op_dec <= 16'h0001 << pm_cont[20:17];
      end
    end
  end

  assign opcode = r_opcode;
  assign op1    = r_op1;
  assign op2    = r_op2;
  assign op3    = r_op3;
  assign data   = r_data;
  assign op_dec = r_op_dec;
  assign valid  = r_valid;

endmodule

// File: tb/tb_idec.sv
// tb/tb_idec.sv - directed and randomized checks of idec against an arithmetic reference model
module tb_idec;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [20:0] pm_cont;
  logic [3:0]  opcode;
  logic [2:0]  op1;
  logic [2:0]  op2;
  logic [2:0]  op3;
  logic [7:0]  data;
  logic [15:0] op_dec;
  logic        valid;

  int tests = 0;
  int fails = 0;

  int m_op, m_op1, m_op2, m_op3, m_data, m_dec, m_valid;

  idec dut (
    .clk(clk), .rst_n(rst_n), .en(en), .pm_cont(pm_cont),
    .opcode(opcode), .op1(op1), .op2(op2), .op3(op3),
    .data(data), .op_dec(op_dec), .valid(valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".opcode"}, int'(opcode), m_op);
    chk({tag, ".op1"},    int'(op1),    m_op1);
    chk({tag, ".op2"},    int'(op2),    m_op2);
    chk({tag, ".op3"},    int'(op3),    m_op3);
    chk({tag, ".data"},   int'(data),   m_data);
    chk({tag, ".op_dec"}, int'(op_dec), m_dec);
    chk({tag, ".valid"},  int'(valid),  m_valid);
  endtask

  task automatic model_clear();
    m_op = 0; m_op1 = 0; m_op2 = 0; m_op3 = 0; m_data = 0; m_dec = 0; m_valid = 0;
  endtask

  // Drive on the falling edge, advance the model at the rising edge, check 1 time unit later
  task automatic step(input logic e, input logic [20:0] w, input string tag);
    int wi;
    @(negedge clk);
    en = e;
    pm_cont = w;
    @(posedge clk);
    wi = int'(w);
    if (e) begin
      m_op   = wi / 131072;
      m_op1  = (wi / 16384) % 8;
      m_op2  = (wi / 2048) % 8;
      m_op3  = (wi / 256) % 8;
      m_data = wi % 256;
      m_dec  = 2 ** m_op;
      m_valid = 1;
    end else begin
      m_valid = 0;
    end
    #1;
    check_all(tag);
  endtask

  // Called at posedge+1: reset pulse entirely between edges
  task automatic async_reset_pulse(input string tag);
    #1;
    rst_n = 1'b0;
    #1;
    model_clear();
    check_all(tag);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    en = 1'b1;
    pm_cont = 21'h1FFFFF;
    model_clear();
    #1;
    check_all("reset_immediate");
    repeat (3) @(posedge clk);
    #1;
    check_all("reset_edges");
    @(negedge clk);
    rst_n = 1'b1;

    step(1'b1, 21'h0A8C02, "basic");
    chk("basic.op_dec_const", int'(op_dec), 32'h0020);
    step(1'b1, 21'h0A8C02, "repeat1");
    step(1'b1, 21'h0A8C02, "repeat2");
    step(1'b1, 21'h0A8C0A, "imm_change");
    chk("imm_change.data_const", int'(data), 32'h0A);

    step(1'b0, 21'h000000, "hold1");
    step(1'b0, 21'h000000, "hold2");
    step(1'b0, 21'h000000, "hold3");
    chk("hold.op_dec_const", int'(op_dec), 32'h0020);

    step(1'b1, 21'h1FFFFF, "ext_ones");
    chk("ext_ones.op_dec_const", int'(op_dec), 32'h8000);
    step(1'b1, 21'h000000, "ext_zero");
    chk("ext_zero.op_dec_const", int'(op_dec), 32'h0001);

    step(1'b1, 21'h0A8C02, "pre_async");
    async_reset_pulse("async_mid");
    step(1'b1, 21'h1E3456, "post_async");

    for (int i = 0; i < 200; i++) begin
      step(($urandom_range(0, 3) != 0), 21'($urandom), "rand");
      if (valid) chk("rand.onehot", int'($onehot(op_dec)), 1);
      if ($urandom_range(0, 24) == 0) async_reset_pulse("rand_async");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/idec.md
# idec

Instruction decoder stage of the microprocessor datapath. Splits each 21-bit program-memory word into opcode, three 3-bit register operand fields and an 8-bit immediate. Registers the fields on the system clock and presents them to the register file, ALU and control unit one cycle after the word is accepted. Also provides a one-hot opcode vector and a valid flag for downstream control.

## Interface

- No parameters; all widths are fixed.
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- en  input  1  decode enable; pm_cont is sampled only when high.
- pm_cont  input  21  instruction word from program memory.
- opcode  output  4  registered pm_cont[20:17].
- op1  output  3  registered pm_cont[16:14]; first register operand (destination).
- op2  output  3  registered pm_cont[13:11]; second register operand (source A).
- op3  output  3  registered pm_cont[10:8]; third register operand (source B).
- data  output  8  registered pm_cont[7:0]; immediate, unsigned, no extension.
- op_dec  output  16  registered one-hot opcode: bit N set when the latched opcode equals N.
- valid  output  1  high for exactly the cycle after an accepted word.

## Operation

- Field map, MSB to LSB: [20:17] opcode, [16:14] op1, [13:11] op2, [10:8] op3, [7:0] data.
  - Bits 0..20 are fully covered; there are no unused or reserved bits.
  - No field is inverted, reordered, sign-extended or validated.
- Rising clk edge with en=1:
  - opcode, op1, op2, op3 and data load from their pm_cont fields.
  - op_dec loads 16'h0001 << pm_cont[20:17].
  - valid loads 1.
- Rising clk edge with en=0:
  - opcode, op1, op2, op3, data and op_dec hold their previous values.
  - valid loads 0.
- All 16 opcode values are decoded identically. No opcode is illegal at this stage, and there is no opcode-dependent field gating.
- op_dec is exactly one-hot whenever valid=1, and equals 1<<opcode at all times after the first accepted word.
- There are no combinational paths from pm_cont to any output.

## Timing

- Latency is 1 cycle: a word sampled at edge k appears on the outputs after edge k, with valid=1 during cycle k+1.
- Throughput is one word per cycle with en held high. Back-to-back words must each produce valid=1 for one cycle with the corresponding fields.
- Reset (rst_n=0) takes effect immediately, independent of clk:
  - opcode=0, op1=0, op2=0, op3=0, data=0, op_dec=16'h0000, valid=0.
  - While rst_n is low, outputs stay at these values and en/pm_cont are ignored.
- Reset release:
  - The first edge with rst_n=1 and en=1 loads normally.
  - Until then op_dec=0. This is the only state in which op_dec is not one-hot.
- Reset asserted mid-stream discards the in-flight word. valid drops within the same cycle, without waiting for a clock edge.
- Changes to pm_cont between edges have no effect on the outputs.

## Test plan

- Reset:
  - Assert rst_n=0 with pm_cont=21'h1FFFFF and en=1.
  - Required: all outputs are 0, including op_dec=0 and valid=0, immediately after assertion and across several clk edges.
- Basic decode:
  - en=1, pm_cont=21'h0A8C02 (010101000110000000010).
  - After the next edge: opcode=4'h5, op1=3'b010, op2=3'b001, op3=3'b100, data=8'h02, op_dec=16'h0020, valid=1.
- Repeat and immediate change:
  - Hold 21'h0A8C02 for two edges, then apply 21'h0A8C0A.
  - Required: the fields stay identical across the repeated word. After the change, data=8'h0A and all other fields are unchanged. valid stays 1 throughout.
- Hold:
  - Load 21'h0A8C0A, then drive en=0 and pm_cont=21'h000000 for 3 edges.
  - Required: the fields and op_dec=16'h0020 hold, and valid=0 from the first en=0 edge.
- Extremes:
  - pm_cont=21'h1FFFFF, then 21'h000000, with en=1.
  - Required for 21'h1FFFFF: opcode=F, op1=op2=op3=7, data=FF, op_dec=16'h8000.
  - Required for 21'h000000: all fields 0 and op_dec=16'h0001.
- Asynchronous reset mid-stream:
  - Pulse rst_n low between clock edges while valid=1.
  - Required: outputs clear before the next edge. The next edge with rst_n=1 and en=1 decodes normally.
